// File: rtl/cheri_pkg.sv
// Shared types for the CHERI load-barrier revocation queue.
// Holds the per-entry lifecycle enum and the entry record kept by cheri_trvk_queue.
package cheri_pkg;

  localparam int unsigned RegAddrW = 5;
  localparam int unsigned CapAddrW = 32;

  // Lifecycle of one outstanding capability load.
  typedef enum logic [1:0] {
    StWaitLd,   // CLC issued, waiting for load data
    StWaitGnt,  // tagged cap loaded, revocation lookup not yet accepted
    StWaitRsp,  // lookup accepted, waiting for the revocation bit
    StDone      // outcome known, waiting to retire in order
  } trvk_state_e;

  typedef struct packed {
    logic                valid;
    logic [RegAddrW-1:0] raddr;
    logic [CapAddrW-1:0] base;
    trvk_state_e         state;
    logic                clr;
  } trvk_entry_t;

endpackage

// File: rtl/cheri_trvk_queue.sv
// In-order queue tracking outstanding capability loads (CLC) through the
// revocation-bit lookup, then retiring each one to the register file.
//
// Ports:
//   clk_i, rst_ni                   clock, async active-low reset
//   rsv_req_i/rsv_addr_i            CLC reservation from the LSU
//   rsv_ready_o                     a slot is free this cycle
//   trsv_en_o/trsv_addr_o           register-ready reservation strobe
//   ld_rvalid_i/ld_cap_valid_i/
//   ld_err_i/ld_base_i              in-order load response
//   rvk_req_o/rvk_addr_o/rvk_gnt_i  revocation-bit lookup request
//   rvk_rvalid_i/rvk_bit_i          in-order lookup response (1 = revoked)
//   trvk_en_o/trvk_addr_o/
//   trvk_clrtag_o                   retire strobe, register, clear-tag
//   busy_o                          at least one entry outstanding
//
// Build option: define CHERI_TRVK_ERRCLR_EN to clear the tag of a register
// whose capability load returned a bus error.
module cheri_trvk_queue
  import cheri_pkg::*;
#(
  parameter int unsigned Depth = 2,
  parameter int unsigned NCAPS = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                rsv_req_i,
  input  logic [RegAddrW-1:0] rsv_addr_i,
  output logic                rsv_ready_o,
  output logic                trsv_en_o,
  output logic [RegAddrW-1:0] trsv_addr_o,
  input  logic                ld_rvalid_i,
  input  logic                ld_cap_valid_i,
  input  logic                ld_err_i,
  input  logic [CapAddrW-1:0] ld_base_i,
  output logic                rvk_req_o,
  output logic [CapAddrW-1:0] rvk_addr_o,
  input  logic                rvk_gnt_i,
  input  logic                rvk_rvalid_i,
  input  logic                rvk_bit_i,
  output logic                trvk_en_o,
  output logic [RegAddrW-1:0] trvk_addr_o,
  output logic                trvk_clrtag_o,
  output logic                busy_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  trvk_entry_t           entries_q [Depth];
  trvk_entry_t           entries_d [Depth];
  logic [PtrW-1:0]       head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]       count_q, count_d;

  logic                  push, pop;
  logic                  ld_found, gnt_found, rsp_found;
  logic [PtrW-1:0]       ld_idx, gnt_idx, rsp_idx;
  logic                  ld_clr;

  // Slot holding the entry that is 'off' places younger than 'base'.
  function automatic logic [PtrW-1:0] age_slot(input logic [PtrW-1:0] base,
                                               input int unsigned     off);
    return PtrW'((32'(base) + off) % Depth);
  endfunction

`ifdef CHERI_TRVK_ERRCLR_EN
  assign ld_clr = ld_err_i;
`else
  assign ld_clr = 1'b0;
`endif

  assign rsv_ready_o = 32'(count_q) < Depth;
  assign push        = rsv_req_i & rsv_ready_o;
  assign trsv_en_o   = push & (rsv_addr_i != '0) & (32'(rsv_addr_i) < NCAPS);
  assign trsv_addr_o = rsv_addr_i;

  assign pop           = entries_q[head_q].valid & (entries_q[head_q].state == StDone);
  assign trvk_en_o     = pop;
  assign trvk_addr_o   = pop ? entries_q[head_q].raddr : '0;
  assign trvk_clrtag_o = pop & entries_q[head_q].clr;

  assign rvk_req_o  = gnt_found;
  assign rvk_addr_o = gnt_found ? entries_q[gnt_idx].base : '0;
  assign busy_o     = count_q != '0;

  // Oldest entry in each waiting state, scanning from the head in age order.
  always_comb begin
    logic [PtrW-1:0] slot;
    slot      = '0;
    ld_found  = 1'b0;
    gnt_found = 1'b0;
    rsp_found = 1'b0;
    ld_idx    = '0;
    gnt_idx   = '0;
    rsp_idx   = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      slot = age_slot(head_q, i);
      if (i < 32'(count_q)) begin
        if (!ld_found && entries_q[slot].state == StWaitLd) begin
          ld_found = 1'b1;
          ld_idx   = slot;
        end
        if (!gnt_found && entries_q[slot].state == StWaitGnt) begin
          gnt_found = 1'b1;
          gnt_idx   = slot;
        end
        if (!rsp_found && entries_q[slot].state == StWaitRsp) begin
          rsp_found = 1'b1;
          rsp_idx   = slot;
        end
      end
    end
  end

  // Each event below targets a different entry state, so they never collide.
  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;

    if (ld_rvalid_i && ld_found) begin
      if (ld_cap_valid_i && !ld_err_i) begin
        entries_d[ld_idx].state = StWaitGnt;
        entries_d[ld_idx].base  = ld_base_i;
      end else begin
        entries_d[ld_idx].state = StDone;
        entries_d[ld_idx].clr   = ld_clr;
      end
    end

    if (gnt_found && rvk_gnt_i) begin
      entries_d[gnt_idx].state = StWaitRsp;
    end

    if (rvk_rvalid_i && rsp_found) begin
      entries_d[rsp_idx].state = StDone;
      entries_d[rsp_idx].clr   = rvk_bit_i;
    end

    if (pop) begin
      entries_d[head_q] = '0;
      head_d            = age_slot(head_q, 1);
    end

    // Push only when not full, so the tail slot is never the entry being popped.
    if (push) begin
      entries_d[tail_q] = '{valid: 1'b1, raddr: rsv_addr_i, base: '0,
                            state: StWaitLd, clr: 1'b0};
      tail_d            = age_slot(tail_q, 1);
    end

    count_d = count_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      entries_q <= '{default: '0};
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  // Responses with nothing waiting for them are dropped; flag them.
  ld_rsp_expected : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                     ld_rvalid_i |-> ld_found);
  rvk_rsp_expected : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                      rvk_rvalid_i |-> rsp_found);

endmodule

// File: tb/tb_cheri_trvk_queue.sv
// Self-checking bench for cheri_trvk_queue: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_cheri_trvk_queue;

  localparam int unsigned Depth = 2;
  localparam int unsigned NCaps = 32;
`ifdef CHERI_TRVK_ERRCLR_EN
  localparam bit ErrClr = 1'b1;
`else
  localparam bit ErrClr = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rsv_req;
  logic [4:0]  rsv_addr;
  logic        rsv_ready;
  logic        trsv_en;
  logic [4:0]  trsv_addr;
  logic        ld_rvalid, ld_cap_valid, ld_err;
  logic [31:0] ld_base;
  logic        rvk_req;
  logic [31:0] rvk_addr;
  logic        rvk_gnt, rvk_rvalid, rvk_bit;
  logic        trvk_en;
  logic [4:0]  trvk_addr;
  logic        trvk_clrtag;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cheri_trvk_queue #(
    .Depth(Depth),
    .NCAPS(NCaps)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .rsv_req_i     (rsv_req),
    .rsv_addr_i    (rsv_addr),
    .rsv_ready_o   (rsv_ready),
    .trsv_en_o     (trsv_en),
    .trsv_addr_o   (trsv_addr),
    .ld_rvalid_i   (ld_rvalid),
    .ld_cap_valid_i(ld_cap_valid),
    .ld_err_i      (ld_err),
    .ld_base_i     (ld_base),
    .rvk_req_o     (rvk_req),
    .rvk_addr_o    (rvk_addr),
    .rvk_gnt_i     (rvk_gnt),
    .rvk_rvalid_i  (rvk_rvalid),
    .rvk_bit_i     (rvk_bit),
    .trvk_en_o     (trvk_en),
    .trvk_addr_o   (trvk_addr),
    .trvk_clrtag_o (trvk_clrtag),
    .busy_o        (busy)
  );

  // Reference model: index 0 is the oldest outstanding load.
  // st: 0 = waiting for load, 1 = waiting for grant, 2 = waiting for lookup, 3 = done.
  typedef struct {
    logic [4:0]  raddr;
    logic [31:0] base;
    int          st;
    bit          clr;
  } m_ent_t;
  m_ent_t mq[$];

  function automatic int find_st(input int s);
    foreach (mq[i]) if (mq[i].st == s) return i;
    return -1;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    int     li, gi, ri;
    bit     retire, do_push;
    m_ent_t e;
    li      = find_st(0);
    gi      = find_st(1);
    ri      = find_st(2);
    retire  = (mq.size() > 0) && (mq[0].st == 3);
    do_push = rsv_req && (mq.size() < Depth);
    if (ld_rvalid && li >= 0) begin
      if (ld_cap_valid && !ld_err) begin
        mq[li].st   = 1;
        mq[li].base = ld_base;
      end else begin
        mq[li].st  = 3;
        mq[li].clr = ld_err && ErrClr;
      end
    end
    if (rvk_gnt && gi >= 0) mq[gi].st = 2;
    if (rvk_rvalid && ri >= 0) begin
      mq[ri].st  = 3;
      mq[ri].clr = rvk_bit;
    end
    if (retire) void'(mq.pop_front());
    if (do_push) begin
      e.raddr = rsv_addr;
      e.base  = '0;
      e.st    = 0;
      e.clr   = 1'b0;
      mq.push_back(e);
    end
  endtask

  task automatic idle_inputs();
    rsv_req      = 1'b0;
    rsv_addr     = '0;
    ld_rvalid    = 1'b0;
    ld_cap_valid = 1'b0;
    ld_err       = 1'b0;
    ld_base      = '0;
    rvk_gnt      = 1'b0;
    rvk_rvalid   = 1'b0;
    rvk_bit      = 1'b0;
  endtask

  // Inputs are changed 1 time unit after the rising edge, outputs sampled 1 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #2;
    tick();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({rsv_ready, trsv_en, rvk_req, trvk_en, trvk_clrtag, busy} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_flags: got rdy/trsv/rvk/trvk/clr/busy=%b expected 100000",
               {rsv_ready, trsv_en, rvk_req, trvk_en, trvk_clrtag, busy});
    end
    n_checks++;
    if (trsv_addr !== 5'd0 || rvk_addr !== 32'd0 || trvk_addr !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_addrs: got %h %h %h expected all zero", trsv_addr, rvk_addr,
               trvk_addr);
    end
    tick();
  endtask

  task automatic test_revoked_cap();
    rsv_req = 1'b1; rsv_addr = 5'd5; #1;
    n_checks++;
    if (trsv_en !== 1'b1 || trsv_addr !== 5'd5) begin
      n_fail++;
      $display("FAIL r5_reserve: got en=%b addr=%0d expected en=1 addr=5", trsv_en, trsv_addr);
    end
    tick();
    idle_inputs();
    ld_rvalid = 1'b1; ld_cap_valid = 1'b1; ld_base = 32'h2000_0040; #1;
    n_checks++;
    if (rvk_req !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL r5_ld_cycle: got rvk_req=%b busy=%b expected 0 1", rvk_req, busy);
    end
    tick();
    idle_inputs(); #1;
    n_checks++;
    if (rvk_req !== 1'b1 || rvk_addr !== 32'h2000_0040) begin
      n_fail++;
      $display("FAIL r5_rvk_req: got req=%b addr=%h expected 1 20000040", rvk_req, rvk_addr);
    end
    rvk_gnt = 1'b1;
    tick();
    idle_inputs();
    rvk_rvalid = 1'b1; rvk_bit = 1'b1; #1;
    n_checks++;
    if (rvk_req !== 1'b0 || trvk_en !== 1'b0) begin
      n_fail++;
      $display("FAIL r5_wait_rsp: got rvk_req=%b trvk_en=%b expected 0 0", rvk_req, trvk_en);
    end
    tick();
    idle_inputs(); #1;
    n_checks++;
    if (trvk_en !== 1'b1 || trvk_addr !== 5'd5 || trvk_clrtag !== 1'b1) begin
      n_fail++;
      $display("FAIL r5_retire: got en=%b addr=%0d clr=%b expected 1 5 1", trvk_en, trvk_addr,
               trvk_clrtag);
    end
    tick();
    n_checks++;
    if (trvk_en !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL r5_empty: got trvk_en=%b busy=%b expected 0 0", trvk_en, busy);
    end
  endtask

  task automatic test_untagged_load();
    rsv_req = 1'b1; rsv_addr = 5'd3;
    tick();
    idle_inputs();
    ld_rvalid = 1'b1; ld_cap_valid = 1'b0; ld_base = 32'hdead_beef;
    tick();
    idle_inputs(); #1;
    n_checks++;
    if (rvk_req !== 1'b0 || trvk_en !== 1'b1 || trvk_addr !== 5'd3 || trvk_clrtag !== 1'b0) begin
      n_fail++;
      $display("FAIL r3_retire: got rvk=%b en=%b addr=%0d clr=%b expected 0 1 3 0", rvk_req,
               trvk_en, trvk_addr, trvk_clrtag);
    end
    tick();
  endtask

  task automatic test_full();
    logic [4:0] addrs[3];
    logic [2:0] rdy_seen, en_seen;
    addrs[0] = 5'd1; addrs[1] = 5'd2; addrs[2] = 5'd4;
    for (int i = 0; i < 3; i++) begin
      rsv_req = 1'b1; rsv_addr = addrs[i]; #1;
      rdy_seen[i] = rsv_ready;
      en_seen[i]  = trsv_en;
      tick();
    end
    idle_inputs();
    n_checks++;
    if (rdy_seen !== 3'b011 || en_seen !== 3'b011) begin
      n_fail++;
      $display("FAIL full_ready: got rdy=%b en=%b expected 011 011", rdy_seen, en_seen);
    end
    ld_rvalid = 1'b1;
    tick();
    tick();
    ld_rvalid = 1'b0; #1;
    n_checks++;
    if (trvk_en !== 1'b1 || trvk_addr !== 5'd2) begin
      n_fail++;
      $display("FAIL full_second_retire: got en=%b addr=%0d expected 1 2", trvk_en, trvk_addr);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || trvk_en !== 1'b0) begin
      n_fail++;
      $display("FAIL full_r4_dropped: got busy=%b trvk_en=%b expected 0 0", busy, trvk_en);
    end
  endtask

  task automatic test_in_order_retire();
    int early;
    rsv_req = 1'b1; rsv_addr = 5'd1;
    tick();
    rsv_addr = 5'd2;
    tick();
    idle_inputs();
    ld_rvalid = 1'b1; ld_cap_valid = 1'b1; ld_base = 32'h0000_1230;
    tick();
    ld_cap_valid = 1'b0;
    tick();
    idle_inputs();
    early = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (trvk_en !== 1'b0 || rvk_req !== 1'b1) early++;
      tick();
    end
    n_checks++;
    if (early != 0) begin
      n_fail++;
      $display("FAIL ooo_hold: got %0d bad cycles expected 0", early);
    end
    rvk_gnt = 1'b1;
    tick();
    rvk_gnt = 1'b0; rvk_rvalid = 1'b1; rvk_bit = 1'b0;
    tick();
    rvk_rvalid = 1'b0; #1;
    n_checks++;
    if (trvk_en !== 1'b1 || trvk_addr !== 5'd1 || trvk_clrtag !== 1'b0) begin
      n_fail++;
      $display("FAIL ooo_r1: got en=%b addr=%0d clr=%b expected 1 1 0", trvk_en, trvk_addr,
               trvk_clrtag);
    end
    tick();
    n_checks++;
    if (trvk_en !== 1'b1 || trvk_addr !== 5'd2 || trvk_clrtag !== 1'b0) begin
      n_fail++;
      $display("FAIL ooo_r2: got en=%b addr=%0d clr=%b expected 1 2 0", trvk_en, trvk_addr,
               trvk_clrtag);
    end
    tick();
  endtask

  task automatic test_reset_midflight();
    int bad;
    rsv_req = 1'b1; rsv_addr = 5'd6;
    tick();
    idle_inputs();
    ld_rvalid = 1'b1; ld_cap_valid = 1'b1; ld_base = 32'h0000_8000;
    tick();
    idle_inputs(); rvk_gnt = 1'b1;
    tick();
    idle_inputs();
    rst_n = 1'b0; #1;
    n_checks++;
    if (busy !== 1'b0 || rvk_req !== 1'b0 || rsv_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid: got busy=%b rvk=%b rdy=%b expected 0 0 1", busy, rvk_req,
               rsv_ready);
    end
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (trvk_en !== 1'b0 || busy !== 1'b0) bad++;
      tick();
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL rst_mid_release: got %0d bad cycles expected 0", bad);
    end
  endtask

  task automatic test_load_error();
    rsv_req = 1'b1; rsv_addr = 5'd7;
    tick();
    idle_inputs();
    ld_rvalid = 1'b1; ld_cap_valid = 1'b1; ld_err = 1'b1; ld_base = 32'h0000_4440;
    tick();
    idle_inputs(); #1;
    n_checks++;
    if (rvk_req !== 1'b0 || trvk_en !== 1'b1 || trvk_addr !== 5'd7 || trvk_clrtag !== ErrClr) begin
      n_fail++;
      $display("FAIL r7_err: got rvk=%b en=%b addr=%0d clr=%b expected 0 1 7 %b", rvk_req,
               trvk_en, trvk_addr, trvk_clrtag, ErrClr);
    end
    tick();
  endtask

  task automatic test_random();
    int          gi;
    bit          exp_rdy, exp_trsv, exp_ret;
    logic [4:0]  exp_taddr;
    logic [31:0] exp_raddr;
    bit          exp_clr;
    mq.delete();
    for (int c = 0; c < 600; c++) begin
      rsv_req      = ($urandom_range(0, 2) != 0);
      rsv_addr     = 5'($urandom_range(0, 31));
      ld_rvalid    = (find_st(0) >= 0) && ($urandom_range(0, 1) != 0);
      ld_cap_valid = ($urandom_range(0, 3) != 0);
      ld_err       = ($urandom_range(0, 4) == 0);
      ld_base      = $urandom;
      rvk_gnt      = ($urandom_range(0, 1) != 0);
      rvk_rvalid   = (find_st(2) >= 0) && ($urandom_range(0, 1) != 0);
      rvk_bit      = ($urandom_range(0, 1) != 0);
      #1;
      exp_rdy   = mq.size() < Depth;
      exp_trsv  = rsv_req && exp_rdy && (rsv_addr != 0) && (32'(rsv_addr) < NCaps);
      gi        = find_st(1);
      exp_raddr = (gi >= 0) ? mq[gi].base : 32'd0;
      exp_ret   = (mq.size() > 0) && (mq[0].st == 3);
      exp_taddr = exp_ret ? mq[0].raddr : 5'd0;
      exp_clr   = exp_ret && mq[0].clr;
      n_checks++;
      if (rsv_ready !== exp_rdy || trsv_en !== exp_trsv || trsv_addr !== rsv_addr) begin
        n_fail++;
        $display("FAIL rnd_rsv c%0d: got rdy=%b en=%b addr=%0d expected %b %b %0d", c,
                 rsv_ready, trsv_en, trsv_addr, exp_rdy, exp_trsv, rsv_addr);
      end
      n_checks++;
      if (rvk_req !== (gi >= 0) || rvk_addr !== exp_raddr) begin
        n_fail++;
        $display("FAIL rnd_rvk c%0d: got req=%b addr=%h expected %b %h", c, rvk_req, rvk_addr,
                 gi >= 0, exp_raddr);
      end
      n_checks++;
      if (trvk_en !== exp_ret || trvk_addr !== exp_taddr || trvk_clrtag !== exp_clr) begin
        n_fail++;
        $display("FAIL rnd_trvk c%0d: got en=%b addr=%0d clr=%b expected %b %0d %b", c,
                 trvk_en, trvk_addr, trvk_clrtag, exp_ret, exp_taddr, exp_clr);
      end
      n_checks++;
      if (busy !== (mq.size() != 0)) begin
        n_fail++;
        $display("FAIL rnd_busy c%0d: got %b expected %b", c, busy, mq.size() != 0);
      end
      model_step();
      @(posedge clk);
      #1;
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_revoked_cap();
    test_untagged_load();
    test_full();
    test_in_order_retire();
    test_reset_midflight();
    test_load_error();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cheri_trvk_queue.md
CHERI_TRVK_QUEUE -- requirements
Module: cheri_trvk_queue

Interface
REQ-001 SHALL have parameter Depth, default 2, number of outstanding capability loads tracked (1..4).
REQ-002 SHALL have parameter NCAPS, default 32, number of capability-capable registers.
REQ-003 SHALL have clk_i  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have rsv_req_i  input  1  LSU issues a capability load (CLC) targeting a register.
REQ-006 SHALL have rsv_addr_i  input  5  destination register of the CLC.
REQ-007 SHALL have rsv_ready_o  output  1  queue accepts a reservation this cycle.
REQ-008 SHALL have trsv_en_o / trsv_addr_o  output  1 / 5  register-ready reservation strobe and address to the register file.
REQ-009 SHALL have ld_rvalid_i  input  1  in-order load data response.
REQ-010 SHALL have ld_cap_valid_i  input  1  tag of the loaded capability.
REQ-011 SHALL have ld_err_i  input  1  bus error on the load.
REQ-012 SHALL have ld_base_i  input  32  base address of the loaded capability.
REQ-013 SHALL have rvk_req_o / rvk_addr_o  output  1 / 32  revocation-bit lookup request and address.
REQ-014 SHALL have rvk_gnt_i  input  1  lookup request accepted.
REQ-015 SHALL have rvk_rvalid_i / rvk_bit_i  input  1 / 1  in-order lookup response; 1 = revoked.
REQ-016 SHALL have trvk_en_o / trvk_addr_o / trvk_clrtag_o  output  1 / 5 / 1  revocation-complete strobe, register, and clear-tag request to the register file.
REQ-017 SHALL have busy_o  output  1  at least one entry is valid.

Function
REQ-018 SHALL hold Depth entries {valid, raddr[4:0], base[31:0], state, clr}; state is one of WAIT_LD, WAIT_GNT, WAIT_RSP, DONE.
REQ-019 SHALL drive rsv_ready_o = (count < Depth); this depends only on registered count, so a pop in the same cycle does not free a slot.
REQ-020 SHALL push on rsv_req_i & rsv_ready_o, entering state WAIT_LD, and drive trsv_en_o = rsv_req_i & rsv_ready_o & (rsv_addr_i != 0) & (rsv_addr_i < NCAPS) combinationally, with trsv_addr_o = rsv_addr_i.
REQ-021 SHALL ignore rsv_req_i when the queue is full; losing the request is an LSU protocol violation.
REQ-022 SHALL apply ld_rvalid_i to the oldest WAIT_LD entry: cap_valid & !err -> WAIT_GNT with base captured; otherwise -> DONE with clr=0.
REQ-023 SHALL drive rvk_req_o for the oldest WAIT_GNT entry, with rvk_addr_o equal to its base; rvk_gnt_i moves that entry to WAIT_RSP.
REQ-024 SHALL apply rvk_rvalid_i to the oldest WAIT_RSP entry, setting DONE with clr = rvk_bit_i.
REQ-025 SHALL retire in order: when the head entry is DONE, drive trvk_en_o=1, trvk_addr_o=raddr and trvk_clrtag_o=clr, and pop it the same cycle; at most one retire per cycle.
REQ-026 SHALL give a minimum latency of ld_rvalid_i -> rvk_req_o of 1 cycle, and rvk_rvalid_i -> trvk_en_o of 1 cycle.
REQ-027 SHALL allow push, load response, grant, lookup response and retire in the same cycle, each acting on a distinct entry; pointers wrap modulo Depth.
REQ-028 SHALL treat ld_rvalid_i with no WAIT_LD entry, and rvk_rvalid_i with no WAIT_RSP entry, as ignored; an assertion flags both.

Reset
REQ-029 SHALL clear all entries, pointers and count to 0 on reset; outputs then read rsv_ready_o=1, trsv_en_o=0, rvk_req_o=0, trvk_en_o=0, trvk_clrtag_o=0, busy_o=0, and all address outputs 0.
REQ-030 SHALL discard in-flight entries on reset mid-operation, with no trvk_en_o pulse; the register file resets its ready bits in the same reset.

Configuration
REQ-031 SHALL, when CHERI_TRVK_ERRCLR_EN is defined, retire an ld_err_i=1 response with clr=1, so the tag is cleared defensively; when it is undefined, clr=0 per REQ-022.

Structure
REQ-032 SHALL place the entry state enum and entry struct typedefs in cheri_pkg.
REQ-033 SHALL be a single module with no sub-module; the pointer/count logic is inline.

Verification
REQ-034 Reserve r5, load cap_valid=1 base 0x2000_0040, grant next cycle, rvk_bit=1 -> rvk_addr_o=0x2000_0040, then trvk_en_o=1, addr=5, clrtag=1.
REQ-035 Reserve r3, load cap_valid=0 -> no rvk_req_o; trvk_en_o=1, addr=3, clrtag=0 one cycle later.
REQ-036 Depth=2: reserve r1, r2, r4 in back-to-back cycles -> third cycle rsv_ready_o=0 and r4 is not pushed (no trsv_en_o).
REQ-037 Out-of-order completion readiness: r1 holds rvk_gnt_i low while r2 is cap_valid=0 -> r2 does not retire until r1 retires, then r2 retires the following cycle.
REQ-038 Assert rst_ni=0 while in WAIT_RSP -> busy_o=0 and no trvk_en_o after release.
REQ-039 ld_err_i=1 on r7 -> clrtag=1 when CHERI_TRVK_ERRCLR_EN is defined, clrtag=0 when it is not.
